// File: rtl/psec5_cmd_pkg.sv
// Shared types and status-register layout for the command sequencer.
// Holds the FSM state enum, the opcode enum, the default counter width and the status packing helper.
package psec5_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_ARM        = 3'd1,
        OP_STOP       = 3'd2,
        OP_FORCE_TRIG = 3'd3,
        OP_READOUT    = 3'd4,
        OP_CLEAR      = 3'd5,
        OP_ILL6       = 3'd6,
        OP_ILL7       = 3'd7
    } opcode_t;

    localparam int CNT_W_DEF      = 4;

    localparam int STAT_STATE_LSB = 6;
    localparam int STAT_ERR_BIT   = 4;
    localparam int STAT_CNT_LSB   = 0;
    localparam int STAT_CNT_W     = 4;

    function automatic logic [7:0] pack_status(input state_t st, input logic err, input logic [3:0] cnt);
        logic [7:0] s;
        s = '0;
        s[STAT_STATE_LSB +: 2]          = st;
        s[STAT_ERR_BIT]                 = err;
        s[STAT_CNT_LSB +: STAT_CNT_W]   = cnt;
        return s;
    endfunction

endpackage

// File: rtl/stable_word_sync.sv
// Multi-flop synchroniser for a word from another clock domain, plus one compare stage.
// Output word is the last stage; o_stable is high when the last two stages agree (no tearing).
module stable_word_sync #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             iclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_word,
    output logic [WIDTH-1:0] o_word,
    output logic             o_stable
);

    logic [WIDTH-1:0] r_stage [SYNC_STAGES+1];

    always_ff @(posedge iclk) begin
        if (rst) begin
            for (int i = 0; i <= SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_word;
            for (int i = 1; i <= SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_word   = r_stage[SYNC_STAGES];
    assign o_stable = (r_stage[SYNC_STAGES] == r_stage[SYNC_STAGES-1]);

endmodule

// File: rtl/cmd_sequencer.sv
// Acquisition command sequencer: decodes toggle-qualified SPI commands into arm/capture/readout control.
// A new command acts on the 4th iclk edge after it appears (2 sync flops + compare + FSM register).
import psec5_cmd_pkg::*;

module cmd_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       iclk,
    input  logic       rst,
    input  logic [7:0] instruction,
    input  logic [7:0] mode,
    input  logic [7:0] trigger_channel_mask,
    input  logic [7:0] trig_in,
    input  logic       rd_ack,
    output logic       acq_en,
    output logic       force_trig,
    output logic       rd_req,
    output logic [7:0] status
);

    logic [23:0]      w_word;
    logic             w_stable;
    logic [7:0]       w_instr;
    logic [7:0]       w_mode;
    logic [7:0]       w_mask;
    opcode_t          w_op;
    logic             w_issue;
    logic             w_legal;
    logic             w_take;
    logic             w_stop;
    logic             w_force;
    logic             w_hit;
    logic             w_unused_bits;

    state_t           r_state;
    logic             r_acq_en;
    logic             r_force_trig;
    logic             r_rd_req;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_tog;
    logic             r_stop_seen;
    logic [5:0]       r_cap_cnt;
    logic [7:0]       r_mask_q;
    logic [5:0]       r_len_q;
    logic             r_cont_q;

    stable_word_sync #(
        .WIDTH       (24),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .iclk     (iclk),
        .rst      (rst),
        .i_word   ({instruction, mode, trigger_channel_mask}),
        .o_word   (w_word),
        .o_stable (w_stable)
    );

    assign w_instr       = w_word[23:16];
    assign w_mode        = w_word[15:8];
    assign w_mask        = w_word[7:0];
    assign w_unused_bits = ^{w_instr[6:3], w_mode[6]};
    assign w_op          = opcode_t'(w_instr[2:0]);
    assign w_issue       = w_stable && (w_instr[7] != r_last_tog);
    assign w_hit         = |(trig_in & r_mask_q);

    // Which opcodes each state accepts; anything else raises the sticky error.
    always_comb begin
        w_legal = 1'b0;
        case (r_state)
            ST_IDLE:  w_legal = w_op inside {OP_NOP, OP_ARM, OP_READOUT, OP_CLEAR};
            ST_ARMED: w_legal = w_op inside {OP_NOP, OP_ARM, OP_STOP, OP_FORCE_TRIG};
            default:  w_legal = (w_op == OP_STOP);
        endcase
    end

    assign w_take  = w_issue && w_legal;
    assign w_stop  = w_take && (w_op == OP_STOP);
    assign w_force = w_take && (w_op == OP_FORCE_TRIG);

    always_ff @(posedge iclk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_acq_en     <= 1'b0;
            r_force_trig <= 1'b0;
            r_rd_req     <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_last_tog   <= 1'b0;
            r_stop_seen  <= 1'b0;
            r_cap_cnt    <= '0;
            r_mask_q     <= '0;
            r_len_q      <= '0;
            r_cont_q     <= 1'b0;
        end else begin
            r_force_trig <= 1'b0;
            if (w_stable) begin
                r_mask_q <= w_mask;
                r_len_q  <= w_mode[5:0];
                r_cont_q <= w_mode[7];
            end
            if (w_issue) begin
                r_last_tog <= w_instr[7];
                if (!w_legal) begin
                    r_err <= 1'b1;
                end else if (w_op == OP_CLEAR) begin
                    r_err <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_take && w_op == OP_ARM) begin
                        r_state  <= ST_ARMED;
                        r_acq_en <= 1'b1;
                    end else if (w_take && w_op == OP_READOUT) begin
                        r_state     <= ST_READOUT;
                        r_rd_req    <= 1'b1;
                        r_stop_seen <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (w_stop) begin
                        r_state  <= ST_IDLE;
                        r_acq_en <= 1'b0;
                    end else if (w_force || w_hit) begin
                        // Length is latched here so later mode writes cannot stretch this capture.
                        r_state      <= ST_CAPTURE;
                        r_cap_cnt    <= r_len_q;
                        r_force_trig <= w_force;
                    end
                end
                ST_CAPTURE: begin
                    if (w_stop) begin
                        r_state  <= ST_IDLE;
                        r_acq_en <= 1'b0;
                    end else if (r_cap_cnt == 6'd0) begin
                        r_state     <= ST_READOUT;
                        r_acq_en    <= 1'b0;
                        r_rd_req    <= 1'b1;
                        r_stop_seen <= 1'b0;
                    end else begin
                        r_cap_cnt <= r_cap_cnt - 6'd1;
                    end
                end
                ST_READOUT: begin
                    if (rd_ack) begin
                        r_rd_req    <= 1'b0;
                        r_stop_seen <= 1'b0;
                        if (r_cont_q && !r_stop_seen && !w_stop) begin
                            r_state  <= ST_ARMED;
                            r_acq_en <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_stop) begin
                        r_stop_seen <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign acq_en     = r_acq_en;
    assign force_trig = r_force_trig;
    assign rd_req     = r_rd_req;
    assign status     = pack_status(r_state, r_err, 4'(r_cnt));

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: command latency, capture length, continuous mode, errors, wrap and reset.
// Expected values are hand-computed constants; inputs change on the falling edge.
module tb_cmd_sequencer;

    logic       iclk;
    logic       rst;
    logic [7:0] instruction;
    logic [7:0] mode;
    logic [7:0] trigger_channel_mask;
    logic [7:0] trig_in;
    logic       rd_ack;
    logic       acq_en;
    logic       force_trig;
    logic       rd_req;
    logic [7:0] status;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_sequencer #(
        .SYNC_STAGES (2),
        .CNT_W       (4)
    ) dut (
        .iclk                 (iclk),
        .rst                  (rst),
        .instruction          (instruction),
        .mode                 (mode),
        .trigger_channel_mask (trigger_channel_mask),
        .trig_in              (trig_in),
        .rd_ack               (rd_ack),
        .acq_en               (acq_en),
        .force_trig           (force_trig),
        .rd_req               (rd_req),
        .status               (status)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a command word and return #1 after the 4th rising edge.
    task automatic issue(input logic [7:0] instr);
        @(negedge iclk);
        instruction = instr;
        repeat (4) @(posedge iclk);
        #1;
    endtask

    task automatic settle();
        repeat (6) @(negedge iclk);
    endtask

    task automatic pulse_ack();
        @(negedge iclk);
        rd_ack = 1'b1;
        @(negedge iclk);
        rd_ack = 1'b0;
    endtask

    task automatic reset_with(input logic [7:0] instr);
        @(negedge iclk);
        instruction = instr;
        rst = 1'b1;
        @(negedge iclk);
        rst = 1'b0;
        settle();
    endtask

    initial begin
        int hi;

        rst = 1'b1;
        instruction = 8'h00;
        mode = 8'h00;
        trigger_channel_mask = 8'h00;
        trig_in = 8'h00;
        rd_ack = 1'b0;

        repeat (3) @(negedge iclk);
        chk("rst_status", status, 8'h00);
        chk("rst_acq_en", acq_en, 1'b0);
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_force", force_trig, 1'b0);
        rst = 1'b0;
        settle();

        // ARM: nothing at edge 3, acq_en at edge 4
        @(negedge iclk);
        instruction = 8'h81;
        repeat (3) @(posedge iclk);
        #1;
        chk("arm_edge3_acq", acq_en, 1'b0);
        @(posedge iclk);
        #1;
        chk("arm_edge4_acq", acq_en, 1'b1);
        chk("arm_status", status, 8'h41);

        // Hit-triggered capture of mode 5 -> six capture cycles, then readout
        @(negedge iclk);
        mode = 8'h05;
        trigger_channel_mask = 8'h04;
        settle();
        chk("armed_hold", status, 8'h41);
        @(negedge iclk);
        trig_in = 8'h04;
        @(negedge iclk);
        trig_in = 8'h00;
        hi = 0;
        for (int i = 0; i < 40 && !rd_req; i++) begin
            if (acq_en) hi++;
            @(negedge iclk);
        end
        chk("cap5_len", hi, 6);
        chk("cap5_rd_req", rd_req, 1'b1);
        chk("cap5_acq_off", acq_en, 1'b0);
        chk("readout_status", status, 8'hC1);
        pulse_ack();
        chk("ack_rd_req", rd_req, 1'b0);
        chk("ack_idle_status", status, 8'h01);

        // Continuous mode with software trigger
        @(negedge iclk);
        mode = 8'h80;
        trigger_channel_mask = 8'h00;
        reset_with(8'h00);
        chk("rst2_status", status, 8'h00);
        issue(8'h81);
        chk("arm2_status", status, 8'h41);
        @(negedge iclk);
        instruction = 8'h03;
        repeat (4) @(posedge iclk);
        #1;
        chk("ftrig_pulse", force_trig, 1'b1);
        chk("ftrig_capture", status, 8'h82);
        @(posedge iclk);
        #1;
        chk("ftrig_pulse_end", force_trig, 1'b0);
        chk("ftrig_readout", status, 8'hC2);
        chk("ftrig_rd_req", rd_req, 1'b1);
        pulse_ack();
        chk("cont_rearm", status, 8'h42);
        chk("cont_acq_en", acq_en, 1'b1);

        // Illegal opcode, then CLEAR
        reset_with(8'h00);
        issue(8'h86);
        chk("illegal_status", status, 8'h10);
        issue(8'h05);
        chk("clear_status", status, 8'h00);

        // Masked-out hits, then STOP racing an enabled hit
        @(negedge iclk);
        mode = 8'h00;
        settle();
        issue(8'h81);
        chk("arm3_status", status, 8'h41);
        @(negedge iclk);
        trig_in = 8'hFF;
        repeat (4) @(negedge iclk);
        trig_in = 8'h00;
        chk("masked_hold", status, 8'h41);
        trigger_channel_mask = 8'h04;
        settle();
        @(negedge iclk);
        instruction = 8'h02;
        repeat (3) @(posedge iclk);
        @(negedge iclk);
        trig_in = 8'h04;
        @(posedge iclk);
        #1;
        chk("stop_beats_hit", status, 8'h02);
        chk("stop_acq_off", acq_en, 1'b0);
        @(negedge iclk);
        trig_in = 8'h00;
        repeat (3) @(negedge iclk);
        chk("stop_stays_idle", status, 8'h02);

        // Sixteen NOPs wrap the counter
        reset_with(8'h00);
        for (int i = 0; i < 16; i++) begin
            issue((i % 2 == 0) ? 8'h80 : 8'h00);
            if (i == 7) chk("nop8_count", status, 8'h08);
        end
        chk("nop16_wrap", status, 8'h00);
        pulse_ack();
        chk("stray_ack", status, 8'h00);

        // Reset during readout, with a simultaneous rd_ack
        issue(8'h84);
        chk("idle_readout", status, 8'hC1);
        chk("idle_readout_req", rd_req, 1'b1);
        @(negedge iclk);
        rst = 1'b1;
        rd_ack = 1'b1;
        @(posedge iclk);
        #1;
        chk("rst_mid_rd_req", rd_req, 1'b0);
        chk("rst_mid_status", status, 8'h00);
        @(negedge iclk);
        rst = 1'b0;
        rd_ack = 1'b0;
        // Toggle bit still high after reset counts as a fresh command
        repeat (3) @(posedge iclk);
        #1;
        chk("post_rst_edge3", rd_req, 1'b0);
        @(posedge iclk);
        #1;
        chk("post_rst_cmd", status, 8'hC1);

        // STOP inside READOUT overrides continuous re-arm
        @(negedge iclk);
        mode = 8'h80;
        settle();
        issue(8'h02);
        chk("rd_stop_status", status, 8'hC2);
        pulse_ack();
        chk("rd_stop_idle", status, 8'h02);
        chk("rd_stop_acq", acq_en, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
